// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - receive FSM state encoding
//   - default timing constants
//   - scancode constants used by the keyboard controller
//   - odd-parity helper
// No ports (package).
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_TIMEOUT_CYCLES_DEF = 20000;
    localparam int PS2_FILTER_LEN_DEF     = 8;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_F3    = 8'h04;
    localparam logic [7:0] SC_F11   = 8'h78;
    localparam logic [7:0] SC_F12   = 8'h07;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_TAB   = 8'h0D;
    localparam logic [7:0] SC_0     = 8'h45;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_7     = 8'h3D;
    localparam logic [7:0] SC_8     = 8'h3E;
    localparam logic [7:0] SC_9     = 8'h46;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Brings the raw PS/2 lines into the CLK domain and detects PS2_CLK falling
// edges. Optional glitch filter on the clock line is compiled in with the
// macro PS2_GLITCH_FILTER_EN; without it the synchronizer output feeds the
// edge detector directly and FILTER_LEN has no effect.
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous, active-high reset
//   PS2_CLK    in   raw keyboard clock line (asynchronous)
//   PS2_DATA   in   raw keyboard data line (asynchronous)
//   ps2_fall   out  one-cycle pulse on a PS2_CLK falling edge
//   ps2_data_s out  synchronized data level, valid in the ps2_fall cycle
// -----------------------------------------------------------------------------
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PS2_CLK,
    input  logic PS2_DATA,
    output logic ps2_fall,
    output logic ps2_data_s
);

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("ps2_line_filter: FILTER_LEN must be at least 1");
    end

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_level;
    logic       clk_level_q;

    // Clock flops reset to the idle line level so reset release is not seen as an edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b00;
        end else begin
            clk_sync  <= {clk_sync[0], PS2_CLK};
            data_sync <= {data_sync[0], PS2_DATA};
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(FILTER_LEN + 1);

    logic [FILT_W-1:0] filt_cnt;
    logic              filt_level;

    // filt_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
        end else if (clk_sync[1] == filt_level) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
            filt_level <= clk_sync[1];
            filt_cnt   <= '0;
        end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
        end
    end

    assign clk_level = filt_level;
`else
    assign clk_level = clk_sync[1];
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_level_q <= 1'b1;
        end else begin
            clk_level_q <= clk_level;
        end
    end

    assign ps2_fall   = clk_level_q & ~clk_level;
    assign ps2_data_s = data_sync[1];

endmodule

// File: rtl/ps2_kb_receiver.sv
// -----------------------------------------------------------------------------
// ps2_kb_receiver
// PS/2 keyboard frame receiver. Decodes 11-bit frames (start, 8 data LSB
// first, odd parity, stop) and keeps a two-byte scancode history.
// Build option: define PS2_GLITCH_FILTER_EN to filter the PS2_CLK line
// (FILTER_LEN consecutive samples) before edge detection.
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous, active-high reset
//   PS2_CLK    in   raw keyboard clock line
//   PS2_DATA   in   raw keyboard data line
//   KBBuffer   out  {previous byte, latest byte}
//   NewByte    out  one-cycle pulse when KBBuffer is updated
//   FrameError out  one-cycle pulse when a frame is discarded
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a start bit (edge with data=0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and parity, then back to ST_IDLE
// -----------------------------------------------------------------------------
module ps2_kb_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF,
    parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [15:0] KBBuffer,
    output logic        NewByte,
    output logic        FrameError
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             ps2_fall;
    logic             ps2_data_s;

    ps2_state_t       state, state_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             parity_bit, parity_next;
    logic [15:0]      kb_next;
    logic             new_byte_next;
    logic             frame_error_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line (
        .CLK        (CLK),
        .RESET      (RESET),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .ps2_fall   (ps2_fall),
        .ps2_data_s (ps2_data_s)
    );

    // Down-counter reloaded on every falling edge; reaching zero outside
    // ST_IDLE means TIMEOUT_CYCLES cycles passed with no edge. It holds at
    // zero rather than wrapping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tmo_cnt <= '0;
        end else if (ps2_fall) begin
            tmo_cnt <= TMO_LOAD;
        end else if ((state != ST_IDLE) && (tmo_cnt != '0)) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            KBBuffer   <= '0;
            NewByte    <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            KBBuffer   <= kb_next;
            NewByte    <= new_byte_next;
            FrameError <= frame_error_next;
        end
    end

    // An edge arriving in the same cycle the timer expires still counts.
    always_comb begin
        state_next       = state;
        bit_cnt_next     = bit_cnt;
        shift_next       = shift_reg;
        parity_next      = parity_bit;
        kb_next          = KBBuffer;
        new_byte_next    = 1'b0;
        frame_error_next = 1'b0;

        if (ps2_fall) begin
            case (state)
                ST_IDLE: begin
                    if (!ps2_data_s) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                        shift_next   = '0;
                    end
                end
                ST_DATA: begin
                    shift_next   = {ps2_data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_next = ps2_data_s;
                    state_next  = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (ps2_data_s && odd_parity_ok(shift_reg, parity_bit)) begin
                        kb_next       = {KBBuffer[7:0], shift_reg};
                        new_byte_next = 1'b1;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end else if (tmo_hit) begin
            state_next       = ST_IDLE;
            bit_cnt_next     = '0;
            shift_next       = '0;
            frame_error_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kb_receiver.sv
module tb_ps2_kb_receiver;
    import ps2_pkg::*;

    localparam int T    = 20000;
    localparam int FL   = 8;
    localparam int HALF = 12;
    // Cycles from driving PS2_CLK low until the edge detector fires and the
    // timer is loaded: two synchronizer stages plus the edge register (plus
    // the filter's FL samples when compiled in). FrameError then follows T
    // cycles after the detected edge.
`ifdef PS2_GLITCH_FILTER_EN
    localparam int LAT = 3 + FL;
`else
    localparam int LAT = 3;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DATA = 1'b1;
    logic [15:0] KBBuffer;
    logic        NewByte;
    logic        FrameError;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int nb_cnt   = 0;
    int fe_cnt   = 0;
    int overlap_cnt = 0;

    logic [15:0] kb_model;
    int          exp_nb;
    int          exp_fe;
    logic [10:0] frame;
    int          k;
    logic        left_idle;

    ps2_kb_receiver #(
        .TIMEOUT_CYCLES (T),
        .FILTER_LEN     (FL)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .KBBuffer   (KBBuffer),
        .NewByte    (NewByte),
        .FrameError (FrameError)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (NewByte)               nb_cnt++;
            if (FrameError)            fe_cnt++;
            if (NewByte && FrameError) overlap_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_parity(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    // Reference: a frame is accepted iff stop=1 and ones(data)+parity is odd.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
        if (stop && ((($countones(b) + int'(par)) % 2) == 1)) begin
            kb_model = {kb_model[7:0], b};
            exp_nb++;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic send_bit(input logic b);
        PS2_DATA = b;
        tick(HALF);
        PS2_CLK = 1'b0;
        tick(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] b,
                                   input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        PS2_DATA = 1'b1;
        tick(4);
        model_frame(b, par, stop);
        check({tag, "_kb"}, 32'(KBBuffer), 32'(kb_model));
        check({tag, "_newbyte"}, nb_cnt, exp_nb);
        check({tag, "_frameerr"}, fe_cnt, exp_fe);
    endtask

    initial begin
        kb_model = '0;
        exp_nb   = 0;
        exp_fe   = 0;

        tick(4);
        RESET = 1'b0;
        tick(2);
        check("reset_kb", 32'(KBBuffer), 32'h0);
        check("reset_newbyte", 32'(NewByte), 32'h0);
        check("reset_frameerr", 32'(FrameError), 32'h0);
        check("reset_state", 32'(dut.state), 32'(ST_IDLE));

        frame_and_check("f1", SC_F1, 1'b1, 1'b1);
        check("f1_const", 32'(KBBuffer), 32'h0005);

        frame_and_check("brk", SC_BREAK, 1'b1, 1'b1);
        frame_and_check("esc", SC_ESC, 1'b0, 1'b1);
        check("brk_esc_const", 32'(KBBuffer), 32'hF076);

        // 0x5A has four ones, so parity 0 is the wrong value.
        frame_and_check("enter_badpar", SC_ENTER, 1'b0, 1'b1);
        check("badpar_kb_kept", 32'(KBBuffer), 32'hF076);
        frame_and_check("after_badpar", SC_TAB, good_parity(SC_TAB), 1'b1);
        frame_and_check("badstop", SC_F12, good_parity(SC_F12), 1'b0);
        frame_and_check("after_badstop", SC_F11, good_parity(SC_F11), 1'b1);

        // Clock stops after the start bit and four data bits.
        frame = {1'b1, good_parity(8'h3C), 8'h3C, 1'b0};
        for (int i = 0; i < 4; i++) send_bit(frame[i]);
        PS2_DATA = frame[4];
        tick(HALF);
        PS2_CLK = 1'b0;
        k = 0;
        while (FrameError !== 1'b1 && k < T + LAT + 100) begin
            tick(1);
            k++;
            if (k == HALF) PS2_CLK = 1'b1;
        end
        check("timeout_latency", k, T + LAT);
        exp_fe++;
        tick(2);
        check("timeout_fe_count", fe_cnt, exp_fe);
        check("timeout_state", 32'(dut.state), 32'(ST_IDLE));
        check("timeout_kb_kept", 32'(KBBuffer), 32'(kb_model));
        PS2_DATA = 1'b1;
        tick(HALF);
        frame_and_check("after_timeout", SC_1, good_parity(SC_1), 1'b1);
        check("after_timeout_low", 32'(KBBuffer[7:0]), 32'h16);

        // Reset in the middle of a frame, with the clock line high.
        frame = {1'b1, good_parity(8'h33), 8'h33, 1'b0};
        for (int i = 0; i < 4; i++) send_bit(frame[i]);
        RESET = 1'b1;
        tick(3);
        RESET = 1'b0;
        kb_model = '0;
        tick(1);
        check("midreset_kb", 32'(KBBuffer), 32'h0);
        check("midreset_state", 32'(dut.state), 32'(ST_IDLE));
        check("midreset_fe", fe_cnt, exp_fe);
        PS2_DATA = 1'b1;
        tick(HALF);
        frame_and_check("after_reset", SC_0, good_parity(SC_0), 1'b1);
        check("after_reset_const", 32'(KBBuffer), 32'h0045);

        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            logic       p;
            logic       s;
            b = 8'($urandom_range(0, 255));
            p = good_parity(b) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 9) != 0);
            frame_and_check($sformatf("rnd%0d", n), b, p, s);
        end

        // Short low glitches on PS2_CLK while idle, data held low.
        PS2_DATA = 1'b0;
        left_idle = 1'b0;
        for (int g = 0; g < 3; g++) begin
            PS2_CLK = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                if (dut.state !== ST_IDLE) left_idle = 1'b1;
            end
            PS2_CLK = 1'b1;
            for (int j = 0; j < 20; j++) begin
                tick(1);
                if (dut.state !== ST_IDLE) left_idle = 1'b1;
            end
        end
`ifdef PS2_GLITCH_FILTER_EN
        check("glitch_stays_idle", 32'(left_idle), 32'h0);
        check("glitch_no_fe", fe_cnt, exp_fe);
`else
        check("glitch_starts_frame", 32'(left_idle), 32'h1);
        k = 0;
        while (fe_cnt == exp_fe && k < T + 200) begin
            tick(1);
            k++;
        end
        exp_fe++;
        check("glitch_timeout_fe", fe_cnt, exp_fe);
        check("glitch_timeout_state", 32'(dut.state), 32'(ST_IDLE));
`endif
        check("glitch_kb_kept", 32'(KBBuffer), 32'(kb_model));
        PS2_DATA = 1'b1;
        tick(HALF);
        frame_and_check("final", SC_ENTER, good_parity(SC_ENTER), 1'b1);

        check("no_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
